// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
//   Shared definitions for the ALU sequencer: FSM state encoding, ALU op-code
//   constants, the requester count and a small id -> one-hot helper.
// -----------------------------------------------------------------------------
package alu_seq_pkg;

    // Number of requesters sharing the ALU.
    localparam int NUM_REQ = 2;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // ALU operation codes. Both 0000 and 0001 select ADD on the shared ALU.
    // The sequencer never decodes these; it passes any 4-bit code through.
    localparam logic [3:0] OP_ADD     = 4'b0000;
    localparam logic [3:0] OP_ADD_ALT = 4'b0001;
    localparam logic [3:0] OP_AND     = 4'b0010;
    localparam logic [3:0] OP_OR      = 4'b0011;
    localparam logic [3:0] OP_XOR     = 4'b0100;
    localparam logic [3:0] OP_SLL     = 4'b0101;
    localparam logic [3:0] OP_SLR     = 4'b0110;
    localparam logic [3:0] OP_SAR     = 4'b0111;

    // Requester index -> one-hot requester mask.
    function automatic logic [NUM_REQ-1:0] id2onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_sequencer_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
//   Two-requester round-robin grant logic with its pointer register.
//
//   Ports
//     clk       in   clock, pointer updates on the rising edge
//     rst       in   asynchronous active-high reset (pointer -> requester 0)
//     req_i     in   [2]  request valid per requester
//     en_i      in   grant enable (sequencer is idle)
//     ready_o   out  [2]  one-hot ready for the granted requester, 0 when !en_i
//     gnt_id_o  out  index of the granted requester
//     accept_o  out  a request is taken on this edge
//
//   A lone valid requester wins. With both or neither valid the pointer
//   decides, so with no requests ready_o simply advertises the pointer.
//   The pointer moves to the other requester on every accept.
// -----------------------------------------------------------------------------
module rr_arbiter2
    import alu_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] ready_o,
    output logic               gnt_id_o,
    output logic               accept_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        unique case (req_i)
            2'b01:   gnt_id_o = 1'b0;
            2'b10:   gnt_id_o = 1'b1;
            default: gnt_id_o = ptr_q;
        endcase
    end

    assign ready_o  = en_i ? id2onehot(gnt_id_o) : '0;
    assign accept_o = |(req_i & ready_o);

    // Serve the other requester next time both are contending.
    assign ptr_d = accept_o ? ~gnt_id_o : ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//   Shares one combinational ALU between two requesters. A request is taken
//   in IDLE, its op/operands are driven to the ALU for one EXEC cycle, and the
//   ALU result is registered and presented in RESP until the consumer takes it.
//
//   Parameters
//     N            operand / result width
//
//   Ports
//     clk, rst                       clock, async active-high reset
//     req_valid[2] / req_ready[2]    per-requester request handshake
//     req_op0/1[4], req_a0/1, req_b0/1[N]   per-requester op and operands
//     ALUControl[4], alu_a, alu_b    drive to the shared ALU (held between ops)
//     alu_y[N]                       combinational ALU result
//     rsp_valid / rsp_ready          response handshake
//     rsp_id, rsp_y[N]               owner and registered result
//     rsp_z, rsp_n                   zero / sign flags of rsp_y
//                                    (only with ALU_SEQ_FLAGS_EN defined)
//
//   Build option: define ALU_SEQ_FLAGS_EN to add the rsp_z / rsp_n outputs.
// -----------------------------------------------------------------------------
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [3:0]         req_op0,
    input  logic [3:0]         req_op1,
    input  logic [N-1:0]       req_a0,
    input  logic [N-1:0]       req_b0,
    input  logic [N-1:0]       req_a1,
    input  logic [N-1:0]       req_b1,
    output logic [3:0]         ALUControl,
    output logic [N-1:0]       alu_a,
    output logic [N-1:0]       alu_b,
    input  logic [N-1:0]       alu_y,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [N-1:0]       rsp_y
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic               rsp_z,
    output logic               rsp_n
`endif
);

    state_e       state_q;
    logic [3:0]   op_q;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic         id_q;
    logic [N-1:0] y_q;
    logic         rsp_valid_q;
`ifdef ALU_SEQ_FLAGS_EN
    logic         z_q;
    logic         n_q;
`endif

    logic         gnt_id;
    logic         accept;
    logic [3:0]   op_d;
    logic [N-1:0] a_d;
    logic [N-1:0] b_d;

    // Grant is only offered while idle; busy-time requests simply wait.
    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_valid),
        .en_i     (state_q == IDLE),
        .ready_o  (req_ready),
        .gnt_id_o (gnt_id),
        .accept_o (accept)
    );

    // Operand select for the granted requester.
    assign op_d = gnt_id ? req_op1 : req_op0;
    assign a_d  = gnt_id ? req_a1  : req_a0;
    assign b_d  = gnt_id ? req_b1  : req_b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            y_q         <= '0;
            rsp_valid_q <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            z_q         <= 1'b0;
            n_q         <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= op_d;
                        a_q     <= a_d;
                        b_q     <= b_d;
                        id_q    <= gnt_id;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU sees the latched op/operands this cycle.
                    y_q         <= alu_y;
`ifdef ALU_SEQ_FLAGS_EN
                    z_q         <= (alu_y == '0);
                    n_q         <= alu_y[N-1];
`endif
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // ALU drive comes straight from the latch registers, so it holds the
    // last request outside EXEC.
    assign ALUControl = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_y      = y_q;
`ifdef ALU_SEQ_FLAGS_EN
    assign rsp_z      = z_q;
    assign rsp_n      = n_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer (N=3) with a behavioural ALU and a transaction
// model of the sequencer. Define ALU_SEQ_FLAGS_EN to also cover rsp_z/rsp_n.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_valid = '0;
    logic [1:0]   req_ready;
    logic [3:0]   req_op0 = '0, req_op1 = '0;
    logic [N-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [3:0]   ALUControl;
    logic [N-1:0] alu_a, alu_b, alu_y;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic         rsp_id;
    logic [N-1:0] rsp_y;
`ifdef ALU_SEQ_FLAGS_EN
    logic         rsp_z, rsp_n;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int dut_nrsp = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .ALUControl(ALUControl), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y)
`ifdef ALU_SEQ_FLAGS_EN
        , .rsp_z(rsp_z), .rsp_n(rsp_n)
`endif
    );

    // Behavioural ALU behind the sequencer.
    function automatic logic [N-1:0] alu_f(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        logic signed [N-1:0] sa;
        sa = a;
        case (op)
            4'd0, 4'd1: return a + b;
            4'd2:       return a & b;
            4'd3:       return a | b;
            4'd4:       return a ^ b;
            4'd5:       return a << b;
            4'd6:       return a >> b;
            4'd7:       return sa >>> b;
            default:    return ~a;
        endcase
    endfunction

    always_comb alu_y = alu_f(ALUControl, alu_a, alu_b);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    // Phase: 0 waiting for a request, 1 ALU busy, 2 response pending.
    int           m_ph = 0;
    logic         m_ptr = 1'b0;
    logic [3:0]   m_op = '0;
    logic [N-1:0] m_a = '0, m_b = '0, m_y = '0, m_pend = '0;
    logic         m_id = 1'b0;
    logic [1:0]   m_acc = '0;

    function automatic logic [1:0] exp_ready_f();
        if (m_ph != 0)           return 2'b00;
        if (req_valid == 2'b01)  return 2'b01;
        if (req_valid == 2'b10)  return 2'b10;
        return m_ptr ? 2'b10 : 2'b01;
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [1:0] r;
        if (rst) begin
            m_ph = 0; m_ptr = 1'b0; m_op = '0; m_a = '0; m_b = '0;
            m_y = '0; m_id = 1'b0; m_acc = '0;
        end else begin
            m_acc = '0;
            case (m_ph)
                0: begin
                    r = exp_ready_f();
                    if ((r & req_valid) != 2'b00) begin
                        m_acc  = r;
                        m_id   = r[1];
                        m_op   = m_id ? req_op1 : req_op0;
                        m_a    = m_id ? req_a1 : req_a0;
                        m_b    = m_id ? req_b1 : req_b0;
                        m_pend = alu_f(m_op, m_a, m_b);
                        m_ptr  = ~m_id;
                        m_ph   = 1;
                    end
                end
                1: begin m_y = m_pend; m_ph = 2; end
                default: if (rsp_ready) m_ph = 0;
            endcase
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("req_ready", req_ready, exp_ready_f());
        chk("rsp_valid", rsp_valid, m_ph == 2);
        chk("ALUControl", ALUControl, m_op);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        if (m_ph == 2) begin
            chk("rsp_y", rsp_y, m_y);
            chk("rsp_id", rsp_id, m_id);
`ifdef ALU_SEQ_FLAGS_EN
            chk("rsp_z", rsp_z, m_y == '0);
            chk("rsp_n", rsp_n, m_y[N-1]);
`endif
        end
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) dut_nrsp++;
    end

    // ---------------- directed helpers ----------------
    task automatic set_req(input int i, input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        if (i == 0) begin req_op0 = op; req_a0 = a; req_b0 = b; end
        else        begin req_op1 = op; req_a1 = a; req_b1 = b; end
        req_valid[i] = 1'b1;
    endtask

    // Waits (bounded) for requester i to be taken; returns #1 after that edge.
    task automatic wait_acc(input int i, input string nm);
        bit ok = 0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(posedge clk); #1;
            if (m_acc[i]) begin ok = 1; req_valid[i] = 1'b0; end
        end
        chk({nm, "_accept"}, ok, 1);
    endtask

    // Counts edges including the accept edge until rsp_valid is seen.
    task automatic wait_rsp(input logic eid, input logic [N-1:0] ey, input string nm);
        int e = 1;
        while (rsp_valid !== 1'b1 && e < 20) begin
            @(posedge clk); #1;
            e++;
        end
        chk({nm, "_latency"}, e, 2);
        chk({nm, "_id"}, rsp_id, eid);
        chk({nm, "_y"}, rsp_y, ey);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [N-1:0] held_y;
        int base;

        // Reset state
        @(posedge clk); #3;
        chk("rst_ready", req_ready, 2'b01);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_y", rsp_y, 0);
        chk("rst_op", ALUControl, 0);
        chk("rst_ab", {alu_a, alu_b}, 0);
        #3 rst = 1'b0;
        @(posedge clk); #1;

        // Basic add
        set_req(0, OP_ADD, 3'd3, 3'd2);
        wait_acc(0, "add");
        wait_rsp(1'b0, 3'd5, "add");

        // Contention after reset: req0 first, then req1
        do_reset();
        set_req(0, OP_AND, 3'd6, 3'd3);
        set_req(1, OP_OR,  3'd4, 3'd1);
        #1 chk("cont_ready", req_ready, 2'b01);
        wait_acc(0, "cont0");
        wait_rsp(1'b0, 3'd2, "cont0");
        wait_acc(1, "cont1");
        wait_rsp(1'b1, 3'd5, "cont1");

        // Backpressure with a stalled second request
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        set_req(0, OP_XOR, 3'd5, 3'd3);
        wait_acc(0, "bp");
        set_req(1, OP_SLL, 3'd3, 3'd1);
        wait_rsp(1'b0, 3'd6, "bp");
        held_y = rsp_y;
        base = dut_nrsp;
        repeat (4) begin
            @(posedge clk); #1;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_hold_y", rsp_y, held_y);
            chk("bp_ready", req_ready, 2'b00);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_single", dut_nrsp - base, 1);
        chk("bp_drop", rsp_valid, 0);
        wait_acc(1, "bp_stalled");
        wait_rsp(1'b1, 3'd6, "bp_stalled");

        // Wrap-around
        @(posedge clk); #1;
        set_req(1, OP_ADD, 3'd7, 3'd1);
        wait_acc(1, "wrap");
        wait_rsp(1'b1, 3'd0, "wrap");
`ifdef ALU_SEQ_FLAGS_EN
        chk("wrap_z", rsp_z, 1);
        chk("wrap_n", rsp_n, 0);
`endif

        // Reset during EXEC aborts the operation
        @(posedge clk); #1;
        set_req(1, OP_ADD, 3'd2, 3'd2);
        wait_acc(1, "abort");
        #2 rst = 1'b1;
        #1;
        chk("abort_valid", rsp_valid, 0);
        chk("abort_ready", req_ready, 2'b01);
        chk("abort_op", ALUControl, 0);
        #3 rst = 1'b0;
        base = dut_nrsp;
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_no_rsp", rsp_valid, 0);
        end
        chk("abort_count", dut_nrsp - base, 0);
        set_req(0, OP_SAR, 3'd4, 3'd1);
        set_req(1, OP_SLR, 3'd6, 3'd1);
        #1 chk("abort_grant", req_ready, 2'b01);
        wait_acc(0, "abort_r0");
        wait_rsp(1'b0, 3'd6, "abort_r0");
        wait_acc(1, "abort_r1");
        wait_rsp(1'b1, 3'd3, "abort_r1");

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (m_acc[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 4'($urandom_range(0, 15)), N'($urandom_range(0, 7)), N'($urandom_range(0, 7)));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (c == 300) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
